imem_prog: RTL and testbench

Parametrised, loadable instruction memory for the pipelined core's fetch stage. It replaces the fixed combinational ROM with a synchronous-read memory: one registered read port with stall hold, and a streaming program-load port with an auto-incrementing write pointer. A bench or boot controller can reload the program without recompiling. The fetch stage reads `q` one cycle after presenting `addr`.

---
 rtl/imem_prog.sv | 175 +++++++++++++++++
 tb/tb_imem_prog.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog.sv
// Loadable instruction memory: one registered read port with stall hold, plus a
// streaming load port with an auto-incrementing write pointer. Define IMEM_PARITY_EN
// to add an even-parity bit per word and the parity_err output.
module imem_prog #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          stall,
  output logic [N-1:0]  q,
  output logic          q_valid,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [N-1:0]  load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          busy,
`ifdef IMEM_PARITY_EN
  output logic          parity_err,
`endif
  output logic [AW:0]   loaded_words
);

  localparam int DEPTH = 2 ** AW;
`ifdef IMEM_PARITY_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [N-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic [AW:0]   loaded_words_q, loaded_words_d;
  logic          parity_err_q, parity_err_d;

  logic          beat_acc;
  logic          beat_term;
  logic          wr_en;
  logic [W-1:0]  wr_word;
  logic [W-1:0]  rd_word;

  // All-zero contents (NOP) at elaboration; zero data carries zero parity.
  logic [W-1:0] mem [DEPTH] = '{default: '0};

  // A beat arriving alongside load_start is dropped: the restart wins.
  assign beat_acc  = (state_q == LOAD) && load_valid && !load_start;
  assign beat_term = beat_acc && (load_last || (wr_ptr_q == AW'(DEPTH - 1)));
  assign wr_en     = beat_acc && reset;

`ifdef IMEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  assign rd_word = mem[addr];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    state_d = state_q;
    unique case (state_q)
      RUN:  if (load_start) state_d = LOAD;
      LOAD: begin
        if (load_start)     state_d = LOAD;
        else if (beat_term) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    if (state_q == LOAD) begin
      load_ready = 1'b1;
      busy       = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    q_d            = q_q;
    q_valid_d      = q_valid_q;
    parity_err_d   = parity_err_q;
    loaded_words_d = loaded_words_q;

    unique case (state_q)
      RUN: begin
        if (load_start) begin
          wr_ptr_d     = '0;
          q_d          = '0;
          q_valid_d    = 1'b0;
          parity_err_d = 1'b0;
        end else if (!stall) begin
          q_d          = rd_word[N-1:0];
          q_valid_d    = 1'b1;
          // XOR over data and stored parity bit is 1 exactly when they disagree.
          parity_err_d = (W > N) ? ^rd_word : 1'b0;
        end
      end
      LOAD: begin
        q_d          = '0;
        q_valid_d    = 1'b0;
        parity_err_d = 1'b0;
        if (load_start) begin
          wr_ptr_d = '0;
        end else if (beat_acc) begin
          // The terminating beat at the last address never advances past it.
          if (!beat_term) wr_ptr_d = wr_ptr_q + AW'(1);
          if (beat_term)  loaded_words_d = {1'b0, wr_ptr_q} + (AW + 1)'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      q_q            <= '0;
      q_valid_q      <= 1'b0;
      parity_err_q   <= 1'b0;
      loaded_words_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      q_q            <= q_d;
      q_valid_q      <= q_valid_d;
      parity_err_q   <= parity_err_d;
      loaded_words_q <= loaded_words_d;
    end
  end

  // NOTE: storage has no reset term; program contents survive reset and map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  assign q            = q_q;
  assign q_valid      = q_valid_q;
  assign loaded_words = loaded_words_q;
`ifdef IMEM_PARITY_EN
  assign parity_err   = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: reset, load/read, stall hold, full load, restart,
// abort-by-reset and (with IMEM_PARITY_EN) parity error detection.
module tb_imem_prog;

  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic          stall;
  logic [N-1:0]  q;
  logic          q_valid;
  logic          load_start;
  logic          load_valid;
  logic [N-1:0]  load_data;
  logic          load_last;
  logic          load_ready;
  logic          busy;
  logic [AW:0]   loaded_words;
`ifdef IMEM_PARITY_EN
  logic          parity_err;
`endif

  int vectors    = 0;
  int miscompares = 0;

  imem_prog #(.N(N), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .stall        (stall),
    .q            (q),
    .q_valid      (q_valid),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .busy         (busy),
`ifdef IMEM_PARITY_EN
    .parity_err   (parity_err),
`endif
    .loaded_words (loaded_words)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [N-1:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [AW-1:0] a, input logic [N-1:0] exp);
    addr = a;
    tick();
    vectors++;
    if (q !== exp || q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: q=%h q_valid=%b, want q=%h q_valid=1", name, q, q_valid, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; addr = '0; stall = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    vectors++;
    if (q !== 32'h0 || q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_q: q=%h q_valid=%b, want 0/0", q, q_valid);
    end
    vectors++;
    if (busy !== 1'b0 || load_ready !== 1'b0 || loaded_words !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: busy=%b ready=%b words=%0d, want 0/0/0", busy, load_ready, loaded_words);
    end
`ifdef IMEM_PARITY_EN
    vectors++;
    if (parity_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_parity: parity_err=%b, want 0", parity_err);
    end
`endif
    reset = 1'b1;
    tick();
    vectors++;
    if (q !== 32'h0 || q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: q=%h q_valid=%b, want 0/1", q, q_valid);
    end
  endtask

  task automatic test_load_read();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || load_ready !== 1'b1 || q_valid !== 1'b0 || q !== 32'h0) begin
      miscompares++;
      $display("FAIL load_enter: busy=%b ready=%b q_valid=%b q=%h, want 1/1/0/0", busy, load_ready, q_valid, q);
    end
    beat(32'hf8000000, 1'b0);
    beat(32'hf8008001, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_midway: busy=%b, want 1", busy);
    end
    beat(32'hcb0e01ce, 1'b1);
    vectors++;
    if (busy !== 1'b0 || load_ready !== 1'b0 || loaded_words !== 7'd3 || q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_done: busy=%b ready=%b words=%0d q_valid=%b, want 0/0/3/0",
               busy, load_ready, loaded_words, q_valid);
    end
    read_expect("read_addr2", 6'd2, 32'hcb0e01ce);
    read_expect("read_addr3", 6'd3, 32'h0);
    read_expect("read_addr0", 6'd0, 32'hf8000000);
  endtask

  task automatic test_stall();
    read_expect("stall_pre", 6'd1, 32'hf8008001);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = AW'(i == 1 ? 0 : 2 + i);
      tick();
      vectors++;
      if (q !== 32'hf8008001 || q_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: q=%h q_valid=%b, want f8008001/1", i, q, q_valid);
      end
    end
    stall = 1'b0;
    read_expect("stall_release", 6'd2, 32'hcb0e01ce);
  endtask

  task automatic test_full_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      beat(N'(i), 1'b0);
      if (i == 62) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL full_beat62: busy=%b, want 1", busy);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || loaded_words !== 7'd64) begin
      miscompares++;
      $display("FAIL full_done: busy=%b words=%0d, want 0/64", busy, loaded_words);
    end
    beat(32'h00000055, 1'b0);
    vectors++;
    if (busy !== 1'b0 || loaded_words !== 7'd64) begin
      miscompares++;
      $display("FAIL full_extra_beat: busy=%b words=%0d, want 0/64", busy, loaded_words);
    end
    read_expect("full_mem0", 6'd0, 32'h0);
    read_expect("full_mem5", 6'd5, 32'h5);
    read_expect("full_mem63", 6'd63, 32'h3f);
  endtask

  task automatic test_restart();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    beat(32'haaaa0000, 1'b0);
    beat(32'haaaa0001, 1'b0);
    load_start = 1'b1;
    beat(32'h12345678, 1'b0);
    load_start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_busy: busy=%b, want 1", busy);
    end
    beat(32'hdeadbeef, 1'b1);
    vectors++;
    if (busy !== 1'b0 || loaded_words !== 7'd1) begin
      miscompares++;
      $display("FAIL restart_done: busy=%b words=%0d, want 0/1", busy, loaded_words);
    end
    read_expect("restart_mem0", 6'd0, 32'hdeadbeef);
    read_expect("restart_mem1", 6'd1, 32'haaaa0001);
    read_expect("restart_mem2", 6'd2, 32'h2);
  endtask

  task automatic test_abort();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b0);
    reset = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || load_ready !== 1'b0 || loaded_words !== 7'd0 || q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: busy=%b ready=%b words=%0d q_valid=%b, want 0/0/0/0",
               busy, load_ready, loaded_words, q_valid);
    end
    reset = 1'b1;
    read_expect("abort_mem0", 6'd0, 32'h11111111);
    read_expect("abort_mem1", 6'd1, 32'h22222222);
    read_expect("abort_mem2", 6'd2, 32'h2);
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    beat(32'h00000001, 1'b1);
    dut.mem[0][N] = 1'b0;
    read_expect("parity_bad_q", 6'd0, 32'h00000001);
    vectors++;
    if (parity_err !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_bad: parity_err=%b, want 1", parity_err);
    end
    read_expect("parity_clean_q", 6'd1, 32'h22222222);
    vectors++;
    if (parity_err !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_clean: parity_err=%b, want 0", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_read();
    test_stall();
    test_full_load();
    test_restart();
    test_abort();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
